// File: rtl/ctrl_sequencer_pkg.sv
// ctrl_sequencer_pkg: shared states, opcodes and control-word layout for the hardwired sequencer.
package ctrl_sequencer_pkg;
   typedef enum logic [3:0] {S_INIT, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_e;
   localparam logic [4:0] OP_LDI  = 5'b01000;
   localparam logic [4:0] OP_ADDI = 5'b01001;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;
   typedef struct packed {
      logic pc_out;
      logic zlo_out;
      logic mdr_out;
      logic c_sign_extended_out;
      logic r_out;
      logic ba_out;
      logic gra;
      logic grb;
      logic mar_enable;
      logic mdr_enable;
      logic ir_enable;
      logic y_enable;
      logic z_enable;
      logic pc_enable;
      logic r_in;
      logic con_enable;
      logic read;
      logic pc_increment;
      logic pc_init_enable;
   } ctrl_word_t;
   function automatic logic op_legal(input logic [4:0] op);
      return op inside {OP_LDI, OP_ADDI, OP_BR, OP_NOP, OP_HALT};
   endfunction
endpackage

// File: rtl/ctrl_sequencer_step_timer.sv
// ctrl_sequencer_step_timer: divides each T-step into STEP_CYCLES clocks and flags its first and last clock.
module ctrl_sequencer_step_timer #(
   parameter int STEP_CYCLES = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic hold,
   output logic step_first,
   output logic step_last
);
   logic [3:0] cnt_q, cnt_d;
   assign step_first = cnt_q == 4'd0;
   assign step_last  = cnt_q == 4'(STEP_CYCLES - 1);
   always_comb cnt_d = hold ? cnt_q : (step_last ? 4'd0 : cnt_q + 4'd1);
   always_ff @(posedge clk or negedge clr)
      if (!clr) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired T-state sequencer driving datapath strobes for fetch, ldi, addi, br, nop and halt.
module ctrl_sequencer
   import ctrl_sequencer_pkg::*;
#(
   parameter int          STEP_CYCLES = 2,
   parameter logic [31:0] PC_INIT     = 32'h0000000F
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [4:0]  opcode,
   input  logic        con_out,
   input  logic        stall,
   input  logic        resume,
   output logic        pc_out,
   output logic        zlo_out,
   output logic        mdr_out,
   output logic        c_sign_extended_out,
   output logic        r_out,
   output logic        ba_out,
   output logic        gra,
   output logic        grb,
   output logic        mar_enable,
   output logic        mdr_enable,
   output logic        ir_enable,
   output logic        y_enable,
   output logic        z_enable,
   output logic        pc_enable,
   output logic        r_in,
   output logic        con_enable,
   output logic        read,
   output logic        pc_increment,
   output logic        pc_init_enable,
   output logic [31:0] pc_init,
   output logic        halted,
   output logic        illegal,
   output logic [31:0] instr_count
);
   state_e      state_q, state_d;
   logic [4:0]  op_q, op_d, op_eff;
   logic        resume_q, resume_d, illegal_q, illegal_d;
   logic        step_first, step_last, advance, sample_op;
   logic [31:0] count_q, count_d;
   ctrl_word_t  cw_q, cw_d;

   ctrl_sequencer_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
      .clk(clk), .clr(clr), .hold(stall), .step_first(step_first), .step_last(step_last)
   );

   // T3 decodes the live opcode on its first clock; later steps use the latched copy
   assign sample_op = state_q == S_T3 && step_first && !stall;
   assign op_eff    = (state_q == S_T3 && step_first) ? opcode : op_q;
   assign advance   = step_last && !stall;

   always_ff @(posedge clk or negedge clr)
      if (!clr) begin
         state_q   <= S_INIT;
         op_q      <= '0;
         resume_q  <= 1'b0;
         illegal_q <= 1'b0;
         count_q   <= '0;
         cw_q      <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         resume_q  <= resume_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
         cw_q      <= cw_d;
      end

   always_comb begin
      state_d = state_q;
      if (advance)
         case (state_q)
            S_INIT:  state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = (op_eff == OP_LDI || op_eff == OP_ADDI || op_eff == OP_BR) ? S_T4 :
                               op_eff == OP_HALT ? S_HALT : S_T0;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = op_q == OP_BR ? S_T6 : S_T0;
            S_T6:    state_d = S_T0;
            S_HALT:  state_d = (resume_q || resume) ? S_T0 : S_HALT;
            default: state_d = S_INIT;
         endcase
   end

   always_comb begin
      op_d      = sample_op ? opcode : op_q;
      illegal_d = illegal_q || (sample_op && !op_legal(opcode));
      resume_d  = state_q == S_HALT && state_d == S_HALT && (resume_q || (resume && !stall));
      count_d   = count_q + 32'(advance && (state_d == S_T0 || state_d == S_HALT) &&
                                state_q inside {S_T3, S_T5, S_T6});
      cw_d      = '0;
      if (step_first && !stall)
         case (state_q)
            S_INIT: cw_d.pc_init_enable = 1'b1;
            S_T0: begin
               cw_d.pc_out       = 1'b1;
               cw_d.mar_enable   = 1'b1;
               cw_d.pc_increment = 1'b1;
               cw_d.z_enable     = 1'b1;
            end
            S_T1: begin
               cw_d.read       = 1'b1;
               cw_d.mdr_enable = 1'b1;
               cw_d.zlo_out    = 1'b1;
               cw_d.pc_enable  = 1'b1;
            end
            S_T2: begin
               cw_d.mdr_out   = 1'b1;
               cw_d.ir_enable = 1'b1;
            end
            S_T3: begin
               cw_d.grb        = op_eff == OP_LDI || op_eff == OP_ADDI;
               cw_d.y_enable   = op_eff == OP_LDI || op_eff == OP_ADDI;
               cw_d.ba_out     = op_eff == OP_LDI;
               cw_d.r_out      = op_eff == OP_ADDI || op_eff == OP_BR;
               cw_d.gra        = op_eff == OP_BR;
               cw_d.con_enable = op_eff == OP_BR;
            end
            S_T4: begin
               cw_d.c_sign_extended_out = op_q != OP_BR;
               cw_d.z_enable            = op_q != OP_BR;
               cw_d.pc_out              = op_q == OP_BR;
               cw_d.y_enable            = op_q == OP_BR;
            end
            S_T5: begin
               cw_d.c_sign_extended_out = op_q == OP_BR;
               cw_d.z_enable            = op_q == OP_BR;
               cw_d.zlo_out             = op_q != OP_BR;
               cw_d.gra                 = op_q != OP_BR;
               cw_d.r_in                = op_q != OP_BR;
            end
            S_T6: begin
               cw_d.zlo_out   = con_out;
               cw_d.pc_enable = con_out;
            end
            default: cw_d = '0;
         endcase
   end

   assign {pc_out, zlo_out, mdr_out, c_sign_extended_out, r_out, ba_out, gra, grb, mar_enable,
           mdr_enable, ir_enable, y_enable, z_enable, pc_enable, r_in, con_enable, read,
           pc_increment, pc_init_enable} = cw_q;
   assign pc_init     = PC_INIT;
   assign halted      = state_q == S_HALT;
   assign illegal     = illegal_q;
   assign instr_count = count_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: three sequencers (1, 2 and 4 clocks per step) checked every cycle against a step-list model.
module tb_ctrl_sequencer;
   localparam int B_PCI = 0, B_PCINC = 1, B_READ = 2, B_CONEN = 3, B_RIN = 4, B_PCEN = 5, B_Z = 6,
                  B_Y = 7, B_IR = 8, B_MDREN = 9, B_MAR = 10, B_GRB = 11, B_GRA = 12, B_BA = 13,
                  B_ROUT = 14, B_CSE = 15, B_MDROUT = 16, B_ZLO = 17, B_PCOUT = 18;
   localparam int SC [3] = '{1, 2, 4};
   localparam logic [4:0] LDI = 5'b01000, ADDI = 5'b01001, BR = 5'b10010, NOP = 5'b11010, HLT = 5'b11011;

   logic clk = 0, clr = 1, stall = 0, resume = 0, con_out = 0;
   logic [4:0] opcode = LDI;
   logic [2:0][18:0] cw;
   logic [2:0][31:0] cnt, pci;
   logic [2:0] halted, illegal;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ctrl_sequencer #(.STEP_CYCLES(SC[g])) dut (
         .clk(clk), .clr(clr), .opcode(opcode), .con_out(con_out), .stall(stall), .resume(resume),
         .pc_out(cw[g][B_PCOUT]), .zlo_out(cw[g][B_ZLO]), .mdr_out(cw[g][B_MDROUT]),
         .c_sign_extended_out(cw[g][B_CSE]), .r_out(cw[g][B_ROUT]), .ba_out(cw[g][B_BA]),
         .gra(cw[g][B_GRA]), .grb(cw[g][B_GRB]), .mar_enable(cw[g][B_MAR]), .mdr_enable(cw[g][B_MDREN]),
         .ir_enable(cw[g][B_IR]), .y_enable(cw[g][B_Y]), .z_enable(cw[g][B_Z]), .pc_enable(cw[g][B_PCEN]),
         .r_in(cw[g][B_RIN]), .con_enable(cw[g][B_CONEN]), .read(cw[g][B_READ]),
         .pc_increment(cw[g][B_PCINC]), .pc_init_enable(cw[g][B_PCI]), .pc_init(pci[g]),
         .halted(halted[g]), .illegal(illegal[g]), .instr_count(cnt[g])
      );
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [18:0] b(input int n);
      return 19'(1) << n;
   endfunction

   function automatic int len(input logic [4:0] op);
      return (op == LDI || op == ADDI) ? 6 : op == BR ? 7 : 4;
   endfunction

   // Strobes of step s (0 = T0) of an instruction with opcode op
   function automatic logic [18:0] mask(input int s, input logic [4:0] op, input logic con);
      logic ld, br;
      ld = op == LDI || op == ADDI;
      br = op == BR;
      case (s)
         0: return b(B_PCOUT) | b(B_MAR) | b(B_PCINC) | b(B_Z);
         1: return b(B_READ) | b(B_MDREN) | b(B_ZLO) | b(B_PCEN);
         2: return b(B_MDROUT) | b(B_IR);
         3: return ld ? (b(B_GRB) | b(B_Y) | (op == LDI ? b(B_BA) : b(B_ROUT))) :
                   br ? (b(B_GRA) | b(B_ROUT) | b(B_CONEN)) : '0;
         4: return ld ? (b(B_CSE) | b(B_Z)) : br ? (b(B_PCOUT) | b(B_Y)) : '0;
         5: return ld ? (b(B_ZLO) | b(B_GRA) | b(B_RIN)) : br ? (b(B_CSE) | b(B_Z)) : '0;
         6: return (br && con) ? (b(B_ZLO) | b(B_PCEN)) : '0;
         default: return '0;
      endcase
   endfunction

   // Model: ph 0=INIT 1=running instruction step k 2=HALT; cy = clock within step
   int ph [3], k [3], cy [3];
   logic [4:0] opl [3];
   logic [18:0] ecw [3];
   logic [31:0] ecnt [3];
   logic eill [3], pend [3];

   always @(posedge clk or negedge clr) begin
      logic first, last;
      logic [4:0] op;
      for (int i = 0; i < 3; i++)
         if (!clr) begin
            ph[i] = 0; k[i] = 0; cy[i] = 0; opl[i] = '0; ecw[i] = '0; ecnt[i] = '0; eill[i] = 0; pend[i] = 0;
         end else if (stall) ecw[i] = '0;
         else begin
            first = cy[i] == 0;
            last = cy[i] == SC[i] - 1;
            op = opl[i];
            if (ph[i] == 1 && k[i] == 3 && first) begin
               op = opcode;
               opl[i] = opcode;
               if (!(opcode inside {LDI, ADDI, BR, NOP, HLT})) eill[i] = 1;
            end
            ecw[i] = !first ? '0 : ph[i] == 0 ? b(B_PCI) : ph[i] == 1 ? mask(k[i], op, con_out) : '0;
            if (ph[i] == 2 && resume) pend[i] = 1;
            if (last) begin
               if (ph[i] == 0) begin ph[i] = 1; k[i] = 0; end
               else if (ph[i] == 2) begin
                  if (pend[i]) begin ph[i] = 1; k[i] = 0; pend[i] = 0; end
               end else if (k[i] == len(opl[i]) - 1) begin
                  ecnt[i] = ecnt[i] + 1;
                  ph[i] = opl[i] == HLT ? 2 : 1;
                  k[i] = 0;
               end else k[i]++;
            end
            cy[i] = last ? 0 : cy[i] + 1;
         end
   end

   always @(negedge clk)
      for (int i = 0; i < 3; i++) begin
         check($sformatf("strobes[S=%0d]", SC[i]), 32'(cw[i]), 32'(ecw[i]));
         check($sformatf("halted_illegal[S=%0d]", SC[i]), {30'd0, halted[i], illegal[i]},
               {30'd0, ph[i] == 2, eill[i]});
         check($sformatf("instr_count[S=%0d]", SC[i]), cnt[i], ecnt[i]);
      end

   initial begin
      int sl;
      sl = 0;
      #1 clr = 0;
      @(negedge clk);
      @(negedge clk);
      clr = 1;
      for (int n = 1; n <= 28; n++) begin
         @(negedge clk);
         if (n == 1) begin
            check("init_strobe", 32'(cw[1]), 32'h00001);
            check("pc_init", pci[1], 32'h0000000F);
         end
         if (n == 2) begin
            check("init_one_clock", 32'(cw[1]), 32'h0);
            check("s1_t0", 32'(cw[0]), 32'h40442);
         end
         if (n == 3) check("s2_t0_after_2", 32'(cw[1]), 32'h40442);
         if (n == 5) check("s4_t0", 32'(cw[2]), 32'h40442);
         if (n == 6) check("s1_count_before", cnt[0], 32'd0);
         if (n == 7) check("s1_count_after", cnt[0], 32'd1);
         if (n == 9) check("s2_ldi_t3", 32'(cw[1]), 32'h02880);
         if (n == 13) begin
            check("s2_ldi_t5", 32'(cw[1]), 32'h21010);
            check("s2_count_before", cnt[1], 32'd0);
         end
         if (n == 14) check("s2_count_after", cnt[1], 32'd1);
         if (n == 15) check("s2_back_to_t0", 32'(cw[1]), 32'h40442);
         if (n == 27) check("s4_count_before", cnt[2], 32'd0);
         if (n == 28) check("s4_count_after", cnt[2], 32'd1);
      end
      for (int n = 0; n < 6000; n++) begin
         @(negedge clk);
         case ($urandom_range(0, 7))
            0: opcode = LDI;
            1: opcode = ADDI;
            2, 3: opcode = BR;
            4: opcode = NOP;
            5: opcode = HLT;
            6: opcode = 5'b00001;
            default: opcode = 5'($urandom);
         endcase
         con_out = 1'($urandom_range(0, 1));
         resume = $urandom_range(0, 19) == 0;
         if (sl == 0 && $urandom_range(0, 15) == 0) sl = $urandom_range(1, 6);
         stall = sl > 0;
         if (sl > 0) sl--;
         if ($urandom_range(0, 499) == 0) begin
            @(posedge clk);
            #3 clr = 0;
            #1;
            for (int i = 0; i < 3; i++) begin
               check("async_reset_strobes", 32'(cw[i]), 32'h0);
               check("async_reset_flags", {30'd0, halted[i], illegal[i]}, 32'h0);
               check("async_reset_count", cnt[i], 32'h0);
            end
            @(negedge clk);
            clr = 1;
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Hardwired control sequencer that replaces bench-driven control with synthesizable RTL. It sits between the instruction register and the `Datapath` control inputs. It steps through T-states for fetch, `ldi`, `addi`, `br`, `nop` and `halt`, and emits the datapath strobes. Step length is parametrised, and it adds stall, halt/resume, illegal-opcode detection and an instruction counter, none of which existed before.

## Interface
- `STEP_CYCLES`, default 2: clocks per T-step (1..15).
- `PC_INIT`, default 32'h0000000F: value driven on `pc_init` during the INIT step.
- `clk` in 1: rising-edge clock.
- `clr` in 1: reset, asynchronous, active-low.
- `opcode` in 5: IR[31:27], sampled at the first cycle of T3.
- `con_out` in 1: branch condition from the CON FF, sampled at the first cycle of T6.
- `stall` in 1: freezes step counter and state; all strobes 0 while high.
- `resume` in 1: leaves HALT on a one-cycle pulse.
- `pc_out, zlo_out, mdr_out, c_sign_extended_out, r_out, ba_out, gra, grb` out 1 each: bus-drive and register-select strobes.
- `mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable, r_in, con_enable, read, pc_increment, pc_init_enable` out 1 each: load/control strobes.
- `pc_init` out 32: equals `PC_INIT` constantly.
- `halted` out 1: high in HALT.
- `illegal` out 1: sticky; set on an undefined opcode.
- `instr_count` out 32: number of completed instructions.

## Operation
- States: INIT, T0, T1, T2, T3, T4, T5, T6, HALT.
- Step strobes:
  - INIT: `pc_init_enable`. Next state T0.
  - T0: `pc_out`, `mar_enable`, `pc_increment`, `z_enable`.
  - T1: `read`, `mdr_enable`, `zlo_out`, `pc_enable`.
  - T2: `mdr_out`, `ir_enable`.
- Decode at T3 by `opcode`:
  - `ldi` (5'b01000): T3 `grb`, `ba_out`, `y_enable`; T4 `c_sign_extended_out`, `z_enable`; T5 `zlo_out`, `gra`, `r_in`; then T0.
  - `addi` (5'b01001): same as `ldi`, but T3 uses `r_out` instead of `ba_out`.
  - `br` (5'b10010): T3 `gra`, `r_out`, `con_enable`; T4 `pc_out`, `y_enable`; T5 `c_sign_extended_out`, `z_enable`; T6 `zlo_out` and `pc_enable` only if `con_out`=1; then T0. There is no extra `pc_increment`.
  - `nop` (5'b11010): T3 has no strobes; then T0.
  - `halt` (5'b11011): go to HALT. `halted`=1 and all strobes are 0. On `resume`=1, go to T0 at the next step boundary.
  - Any other opcode: set `illegal` and treat as `nop`.
- `instr_count` increments by 1 on the last cycle of an instruction's final step (T5, T6 or T3), and when entering HALT. It wraps from 2^32-1 to 0.

## Timing
- Each step lasts `STEP_CYCLES` clocks. Strobes are high only on the first clock of a step; the remaining clocks are all-zero.
- With `STEP_CYCLES`=1, strobes are continuous per step.
- Strobes are registered outputs (Moore), with no combinational path from inputs.
- Latency: `ldi` and `addi` take 6 steps, `br` 7 steps, `nop` 4 steps, measured from T0.
- Reset (`clr`=0, asynchronous):
  - state goes to INIT and the step counter to 0;
  - all strobes, `halted`, `illegal` and `instr_count` go to 0.
  - The first INIT strobe appears on the first rising edge after `clr` rises.
- Reset mid-instruction aborts the instruction immediately; no partial count is kept.
- `stall`:
  - Holds the counter and state.
  - If stall starts in a step's first cycle, that step's strobes are re-issued on the first cycle after stall drops.
  - `stall` has priority over `resume`.
- `resume` outside HALT is ignored.
- `con_out` is sampled only at the T6 first cycle; changes at any other time are ignored.

## Structure
- A shared package holds the state enum, opcode constants (`OP_LDI`, `OP_ADDI`, `OP_BR`, `OP_NOP`, `OP_HALT`) and a packed control-word struct.
- Sub-module `step_timer`: a counter parameterised by `STEP_CYCLES` that emits `step_first` and `step_last` pulses and has a `hold` input driven by `stall`.
- The sequencer decodes state plus latched opcode into a control word, which is registered once.

## Test plan
- Reset release, `STEP_CYCLES`=2:
  - `pc_init_enable`=1 for exactly 1 clock;
  - `pc_init`=32'h0000000F;
  - T0 strobes appear 2 clocks later.
- `ldi` (opcode 5'b01000):
  - strobe sequence INIT, T0..T5 matches the spec exactly;
  - `instr_count` goes 0→1 at the end of T5;
  - next state is T0.
- `br`, once with `con_out`=1 and once with `con_out`=0:
  - taken: T6 asserts `zlo_out` and `pc_enable` for 1 clock;
  - not taken: T6 is all-zero;
  - both: no `pc_increment` in T6.
- `stall` high for 5 clocks during the first cycle of T4:
  - strobes are 0 while stalled;
  - T4 strobes are re-issued once after release;
  - total latency grows by 5.
- `halt` (5'b11011):
  - `halted`=1 and `instr_count` increments;
  - `resume` pulse → T0 at the next step boundary;
  - an undefined opcode 5'b00001 sets `illegal`=1 (sticky) and finishes as `nop`.
- Assert `clr`=0 mid-T5 of `addi`:
  - all outputs go to 0 asynchronously;
  - INIT is re-entered after release.
- Repeat the `ldi` scenario with `STEP_CYCLES`=1 and 4 to check step-length scaling.
